// File: rtl/multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_pkg
//   Shared definitions for the multicycle MIPS-subset controller and its
//   datapath: FSM state encoding, opcode/funct values, ALU and mux select
//   codes, and a small R-type decode helper.
//   The optional exception state S_EXC exists only when OVERFLOW_EXC_EN is
//   defined.
// ---------------------------------------------------------------------------
package multicycle_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RST,
    S_FETCH,
    S_WAIT,
    S_IR,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_EXEC_I,
    S_WB_I,
    S_MEM_ADDR,
    S_LW_RD,
    S_LW_WAIT,
    S_LW_MDR,
    S_LW_WB,
    S_SW,
    S_BRANCH,
    S_JUMP,
    S_ILLEGAL
`ifdef OVERFLOW_EXC_EN
    , S_EXC
`endif
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;

  // ALU operation codes
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;

  // Register destination select
  localparam logic [2:0] REGDST_RT = 3'd0;
  localparam logic [2:0] REGDST_RD = 3'd1;

  // Writeback source select
  localparam logic [3:0] M2R_ALUOUT = 4'd0;
  localparam logic [3:0] M2R_MDR    = 4'd1;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC = 2'd0;
  localparam logic [1:0] SRCA_A  = 2'd1;

  // ALU operand B select
  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  // PC source select (exception vector code is a module parameter)
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  function automatic logic rtype_supported(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND);
  endfunction

  function automatic logic [2:0] rtype_alu_op(input logic [5:0] funct);
    logic [2:0] op;
    case (funct)
      FN_ADD:  op = ALU_ADD;
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      default: op = ALU_PASS;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_counter.sv
// ---------------------------------------------------------------------------
// wait_counter
//   Loadable down-counter used to stretch memory reads by a fixed number of
//   wait cycles. o_done is high in the last cycle of the wait window.
// Ports
//   i_clk       clock
//   i_reset_n   synchronous active-low reset (count cleared)
//   i_load      load i_load_val (takes priority over i_dec)
//   i_dec       decrement by one while non-zero
//   i_load_val  value loaded on i_load
//   o_done      count is at or below one
// ---------------------------------------------------------------------------
module wait_counter #(
  parameter int unsigned  MAX_COUNT = 2,
  localparam int unsigned CW        = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_load,
  input  logic          i_dec,
  input  logic [CW-1:0] i_load_val,
  output logic          o_done
);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_done = (r_count <= CW'(1));

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Multicycle MIPS-subset control FSM. Sequences fetch / wait / decode /
//   execute / writeback for R-type (add, sub, and), addi/addiu, lw/sw,
//   beq/bne and j, with MEM_WAIT wait cycles after every memory read and an
//   illegal-instruction path.
//   Optional feature macro: OVERFLOW_EXC_EN -- arithmetic overflow in
//   add/sub/addi and illegal instructions divert to an exception state that
//   loads EPC and jumps to the exception vector.
// Parameters
//   MEM_WAIT        memory read latency in cycles (0..15)
//   ALU_SEL_W       width of seletor_ALU
//   EXC_VECTOR_SEL  seletor_PCSrc code for the exception vector
// Ports
//   clk, reset                   clock, synchronous active-low reset
//   overflow,NG,zero,EQ,GT,LT    ALU flags
//   OPCODE, FUNCT                IR fields
//   PC_write .. EPC_write        datapath write enables
//   seletor_*                    datapath mux / ALU selects
//   reset_out                    datapath reset pulse
// ---------------------------------------------------------------------------
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT       = 2,
  parameter int unsigned ALU_SEL_W      = 3,
  parameter logic [1:0]  EXC_VECTOR_SEL = 2'd3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 overflow,
  input  logic                 NG,
  input  logic                 zero,
  input  logic                 EQ,
  input  logic                 GT,
  input  logic                 LT,
  input  logic [5:0]           OPCODE,
  input  logic [5:0]           FUNCT,
  output logic                 PC_write,
  output logic                 PC_write_cond,
  output logic                 MEM_write,
  output logic                 IR_write,
  output logic                 RB_write,
  output logic                 AB_write,
  output logic                 ALUOut_write,
  output logic                 MDR_write,
  output logic                 EPC_write,
  output logic [ALU_SEL_W-1:0] seletor_ALU,
  output logic [2:0]           seletor_RegDst,
  output logic [3:0]           seletor_memToReg,
  output logic [1:0]           seletor_aluScrA,
  output logic [1:0]           seletor_aluScrB,
  output logic [1:0]           seletor_PCSrc,
  output logic                 reset_out
);

  localparam int unsigned CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

  state_t r_state;
  state_t w_next;
  logic   w_wait_done;
  logic   w_wait_load;
  logic   w_wait_dec;
  logic   w_branch_taken;
  logic   w_unused_inputs;

`ifdef OVERFLOW_EXC_EN
  assign w_unused_inputs = &{1'b0, NG, zero, GT, LT};
`else
  assign w_unused_inputs = &{1'b0, NG, zero, GT, LT, overflow, EXC_VECTOR_SEL};
`endif

  // The counter is armed in the read-issuing state and counts down in the
  // following wait state, so WAIT lasts exactly MEM_WAIT cycles.
  assign w_wait_load = (r_state == S_FETCH) || (r_state == S_LW_RD);
  assign w_wait_dec  = (r_state == S_WAIT)  || (r_state == S_LW_WAIT);

  wait_counter #(
    .MAX_COUNT (MEM_WAIT)
  ) u_wait_counter (
    .i_clk      (clk),
    .i_reset_n  (reset),
    .i_load     (w_wait_load),
    .i_dec      (w_wait_dec),
    .i_load_val (CW'(MEM_WAIT)),
    .o_done     (w_wait_done)
  );

  // OPCODE comes from the IR, which is stable from the IR state until the
  // next fetch, so the branch sense can be resolved here from EQ.
  assign w_branch_taken = ((OPCODE == OP_BEQ) &&  EQ) ||
                          ((OPCODE == OP_BNE) && !EQ);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_RST;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST:   w_next = S_FETCH;
      S_FETCH: w_next = (MEM_WAIT > 0) ? S_WAIT : S_IR;
      S_WAIT:  if (w_wait_done) w_next = S_IR;
      S_IR:    w_next = S_DECODE;
      S_DECODE: begin
        case (OPCODE)
          OP_RTYPE:         w_next = rtype_supported(FUNCT) ? S_EXEC_R : S_ILLEGAL;
          OP_ADDI,
          OP_ADDIU:         w_next = S_EXEC_I;
          OP_LW, OP_SW:     w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:   w_next = S_BRANCH;
          OP_J:             w_next = S_JUMP;
          default:          w_next = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        w_next = S_WB_R;
`ifdef OVERFLOW_EXC_EN
        if (overflow && ((FUNCT == FN_ADD) || (FUNCT == FN_SUB))) w_next = S_EXC;
`endif
      end
      S_EXEC_I: begin
        w_next = S_WB_I;
`ifdef OVERFLOW_EXC_EN
        if (overflow && (OPCODE == OP_ADDI)) w_next = S_EXC;
`endif
      end
      S_MEM_ADDR: w_next = (OPCODE == OP_LW) ? S_LW_RD : S_SW;
      S_LW_RD:    w_next = (MEM_WAIT > 0) ? S_LW_WAIT : S_LW_MDR;
      S_LW_WAIT:  if (w_wait_done) w_next = S_LW_MDR;
      S_LW_MDR:   w_next = S_LW_WB;
`ifdef OVERFLOW_EXC_EN
      S_ILLEGAL:  w_next = S_EXC;
      S_EXC:      w_next = S_FETCH;
`else
      S_ILLEGAL:  w_next = S_FETCH;
`endif
      S_WB_R, S_WB_I, S_LW_WB, S_SW, S_BRANCH, S_JUMP: w_next = S_FETCH;
      default:    w_next = S_RST;
    endcase
  end

  always_comb begin
    PC_write         = 1'b0;
    PC_write_cond    = 1'b0;
    MEM_write        = 1'b0;
    IR_write         = 1'b0;
    RB_write         = 1'b0;
    AB_write         = 1'b0;
    ALUOut_write     = 1'b0;
    MDR_write        = 1'b0;
    EPC_write        = 1'b0;
    seletor_ALU      = '0;
    seletor_RegDst   = '0;
    seletor_memToReg = '0;
    seletor_aluScrA  = '0;
    seletor_aluScrB  = '0;
    seletor_PCSrc    = '0;
    reset_out        = 1'b0;
    case (r_state)
      S_RST: reset_out = 1'b1;
      S_FETCH: begin
        seletor_aluScrA = SRCA_PC;
        seletor_aluScrB = SRCB_FOUR;
        seletor_ALU     = ALU_SEL_W'(ALU_ADD);
        seletor_PCSrc   = PCSRC_ALU;
        PC_write        = 1'b1;
      end
      S_IR: IR_write = 1'b1;
      S_DECODE: begin
        AB_write        = 1'b1;
        seletor_aluScrA = SRCA_PC;
        seletor_aluScrB = SRCB_IMM_SH;
        seletor_ALU     = ALU_SEL_W'(ALU_ADD);
        ALUOut_write    = 1'b1;
      end
      S_EXEC_R: begin
        seletor_aluScrA = SRCA_A;
        seletor_aluScrB = SRCB_B;
        seletor_ALU     = ALU_SEL_W'(rtype_alu_op(FUNCT));
        ALUOut_write    = 1'b1;
      end
      S_WB_R: begin
        seletor_RegDst   = REGDST_RD;
        seletor_memToReg = M2R_ALUOUT;
        RB_write         = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        seletor_aluScrA = SRCA_A;
        seletor_aluScrB = SRCB_IMM;
        seletor_ALU     = ALU_SEL_W'(ALU_ADD);
        ALUOut_write    = 1'b1;
      end
      S_WB_I: begin
        seletor_RegDst   = REGDST_RT;
        seletor_memToReg = M2R_ALUOUT;
        RB_write         = 1'b1;
      end
      S_LW_MDR: MDR_write = 1'b1;
      S_LW_WB: begin
        seletor_RegDst   = REGDST_RT;
        seletor_memToReg = M2R_MDR;
        RB_write         = 1'b1;
      end
      S_SW: MEM_write = 1'b1;
      S_BRANCH: begin
        seletor_aluScrA = SRCA_A;
        seletor_aluScrB = SRCB_B;
        seletor_ALU     = ALU_SEL_W'(ALU_SUB);
        seletor_PCSrc   = PCSRC_ALUOUT;
        PC_write_cond   = w_branch_taken;
      end
      S_JUMP: begin
        seletor_PCSrc = PCSRC_JUMP;
        PC_write      = 1'b1;
      end
`ifdef OVERFLOW_EXC_EN
      S_EXC: begin
        EPC_write     = 1'b1;
        seletor_PCSrc = EXC_VECTOR_SEL;
        PC_write      = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  localparam int unsigned W = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       overflow, NG, zero, EQ, GT, LT;
  logic [5:0] OPCODE, FUNCT;
  logic       PC_write, PC_write_cond, MEM_write, IR_write, RB_write;
  logic       AB_write, ALUOut_write, MDR_write, EPC_write, reset_out;
  logic [2:0] seletor_ALU, seletor_RegDst;
  logic [3:0] seletor_memToReg;
  logic [1:0] seletor_aluScrA, seletor_aluScrB, seletor_PCSrc;

  multicycle_ctrl #(
    .MEM_WAIT       (W),
    .ALU_SEL_W      (3),
    .EXC_VECTOR_SEL (2'd3)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .overflow         (overflow),
    .NG               (NG),
    .zero             (zero),
    .EQ               (EQ),
    .GT               (GT),
    .LT               (LT),
    .OPCODE           (OPCODE),
    .FUNCT            (FUNCT),
    .PC_write         (PC_write),
    .PC_write_cond    (PC_write_cond),
    .MEM_write        (MEM_write),
    .IR_write         (IR_write),
    .RB_write         (RB_write),
    .AB_write         (AB_write),
    .ALUOut_write     (ALUOut_write),
    .MDR_write        (MDR_write),
    .EPC_write        (EPC_write),
    .seletor_ALU      (seletor_ALU),
    .seletor_RegDst   (seletor_RegDst),
    .seletor_memToReg (seletor_memToReg),
    .seletor_aluScrA  (seletor_aluScrA),
    .seletor_aluScrB  (seletor_aluScrB),
    .seletor_PCSrc    (seletor_PCSrc),
    .reset_out        (reset_out)
  );

  always #5 clk = ~clk;

  // Expected step codes
  localparam int T_RST = 0, T_FETCH = 1, T_WAIT = 2, T_IR = 3, T_DEC = 4;
  localparam int T_EXR_ADD = 5, T_EXR_SUB = 6, T_EXR_AND = 7, T_WBR = 8;
  localparam int T_EXI = 9, T_WBI = 10, T_MADDR = 11, T_LWRD = 12;
  localparam int T_LWMDR = 13, T_LWWB = 14, T_SW = 15, T_BR_T = 16;
  localparam int T_BR_N = 17, T_J = 18, T_ILL = 19, T_EXC = 20;

  // strobes order: PCw PCc MEMw IRw RBw ABw AOw MDRw EPCw rst
  function automatic logic [25:0] mk(input logic [9:0] s, input logic [2:0] alu,
                                     input logic [2:0] rd, input logic [3:0] m2r,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] pcs);
    return {s, alu, rd, m2r, a, b, pcs};
  endfunction

  function automatic logic [25:0] step(input int t);
    case (t)
      T_RST:     return mk(10'b0000000001, 3'd0, 3'd0, 4'd0, 2'd0, 2'd0, 2'd0);
      T_FETCH:   return mk(10'b1000000000, 3'd1, 3'd0, 4'd0, 2'd0, 2'd1, 2'd0);
      T_IR:      return mk(10'b0001000000, 3'd0, 3'd0, 4'd0, 2'd0, 2'd0, 2'd0);
      T_DEC:     return mk(10'b0000011000, 3'd1, 3'd0, 4'd0, 2'd0, 2'd3, 2'd0);
      T_EXR_ADD: return mk(10'b0000001000, 3'd1, 3'd0, 4'd0, 2'd1, 2'd0, 2'd0);
      T_EXR_SUB: return mk(10'b0000001000, 3'd2, 3'd0, 4'd0, 2'd1, 2'd0, 2'd0);
      T_EXR_AND: return mk(10'b0000001000, 3'd3, 3'd0, 4'd0, 2'd1, 2'd0, 2'd0);
      T_WBR:     return mk(10'b0000100000, 3'd0, 3'd1, 4'd0, 2'd0, 2'd0, 2'd0);
      T_EXI,
      T_MADDR:   return mk(10'b0000001000, 3'd1, 3'd0, 4'd0, 2'd1, 2'd2, 2'd0);
      T_WBI:     return mk(10'b0000100000, 3'd0, 3'd0, 4'd0, 2'd0, 2'd0, 2'd0);
      T_LWMDR:   return mk(10'b0000000100, 3'd0, 3'd0, 4'd0, 2'd0, 2'd0, 2'd0);
      T_LWWB:    return mk(10'b0000100000, 3'd0, 3'd0, 4'd1, 2'd0, 2'd0, 2'd0);
      T_SW:      return mk(10'b0010000000, 3'd0, 3'd0, 4'd0, 2'd0, 2'd0, 2'd0);
      T_BR_T:    return mk(10'b0100000000, 3'd2, 3'd0, 4'd0, 2'd1, 2'd0, 2'd1);
      T_BR_N:    return mk(10'b0000000000, 3'd2, 3'd0, 4'd0, 2'd1, 2'd0, 2'd1);
      T_J:       return mk(10'b1000000000, 3'd0, 3'd0, 4'd0, 2'd0, 2'd0, 2'd2);
      T_EXC:     return mk(10'b1000000010, 3'd0, 3'd0, 4'd0, 2'd0, 2'd0, 2'd3);
      default:   return '0; // WAIT, LW_RD, ILLEGAL: everything idle
    endcase
  endfunction

  function automatic string tname(input int t);
    case (t)
      T_RST: return "rst";       T_FETCH: return "fetch";   T_WAIT: return "wait";
      T_IR: return "ir";         T_DEC: return "decode";    T_EXR_ADD: return "exec_add";
      T_EXR_SUB: return "exec_sub"; T_EXR_AND: return "exec_and"; T_WBR: return "wb_r";
      T_EXI: return "exec_i";    T_WBI: return "wb_i";      T_MADDR: return "mem_addr";
      T_LWRD: return "lw_rd";    T_LWMDR: return "lw_mdr";  T_LWWB: return "lw_wb";
      T_SW: return "sw";         T_BR_T: return "branch_taken"; T_BR_N: return "branch_not";
      T_J: return "jump";        T_ILL: return "illegal";   T_EXC: return "exc";
      default: return "?";
    endcase
  endfunction

  logic [25:0] q_exp[$];
  int          q_tag[$];
  int          total = 0;
  int          bad = 0;
  logic        done = 1'b0;
  int          instr_no = 0;

  task automatic push(input int t);
    q_exp.push_back(step(t));
    q_tag.push_back(t);
  endtask

  task automatic start(input logic [5:0] op, input logic [5:0] fn,
                       input logic eq, input logic ovf);
    OPCODE   = op;
    FUNCT    = fn;
    EQ       = eq;
    overflow = ovf;
    instr_no++;
    push(T_FETCH);
    for (int unsigned i = 0; i < W; i++) push(T_WAIT);
    push(T_IR);
    push(T_DEC);
  endtask

  // Advance exactly as many cycles as expectations are queued.
  task automatic run();
    int n;
    n = q_exp.size();
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle the controller presents a new output vector.
  always @(negedge clk) begin
    logic [25:0] act;
    logic [25:0] e;
    int          t;
    act = {PC_write, PC_write_cond, MEM_write, IR_write, RB_write, AB_write,
           ALUOut_write, MDR_write, EPC_write, reset_out, seletor_ALU,
           seletor_RegDst, seletor_memToReg, seletor_aluScrA, seletor_aluScrB,
           seletor_PCSrc};
    if (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      t = q_tag.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s (instr %0d) at %0t: got %b expected %b",
                 tname(t), instr_no, $time, act, e);
      end
    end else if (done) begin
      total++;
      if (q_exp.size() != 0) begin
        bad++;
        $display("FAIL drain: %0d expectations left, required 0", q_exp.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    overflow = 1'b0; NG = 1'b0; zero = 1'b0; EQ = 1'b0; GT = 1'b0; LT = 1'b0;
    OPCODE = 6'd0; FUNCT = 6'd0;

    // reset low for three edges, then released
    @(posedge clk); #1;
    push(T_RST); push(T_RST); push(T_RST);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // R-type: add, sub, and; WB 6 cycles after FETCH, next FETCH at 7
    start(6'd0, 6'd32, 1'b0, 1'b0); push(T_EXR_ADD); push(T_WBR); run();
    start(6'd0, 6'd34, 1'b0, 1'b0); push(T_EXR_SUB); push(T_WBR); run();
    start(6'd0, 6'd36, 1'b0, 1'b0); push(T_EXR_AND); push(T_WBR); run();
    // and never traps on overflow
    start(6'd0, 6'd36, 1'b0, 1'b1); push(T_EXR_AND); push(T_WBR); run();

    // addiu never traps; addi without overflow writes back
    start(6'd9, 6'd0, 1'b0, 1'b1); push(T_EXI); push(T_WBI); run();
    start(6'd8, 6'd0, 1'b0, 1'b0); push(T_EXI); push(T_WBI); run();

    // overflow on addi and add
`ifdef OVERFLOW_EXC_EN
    start(6'd8, 6'd0, 1'b0, 1'b1); push(T_EXI); push(T_EXC); run();
    start(6'd0, 6'd32, 1'b0, 1'b1); push(T_EXR_ADD); push(T_EXC); run();
`else
    start(6'd8, 6'd0, 1'b0, 1'b1); push(T_EXI); push(T_WBI); run();
    start(6'd0, 6'd32, 1'b0, 1'b1); push(T_EXR_ADD); push(T_WBR); run();
`endif

    // lw: MDR at cycle 9, writeback at cycle 10
    start(6'd35, 6'd0, 1'b0, 1'b0);
    push(T_MADDR); push(T_LWRD);
    for (int unsigned i = 0; i < W; i++) push(T_WAIT);
    push(T_LWMDR); push(T_LWWB); run();

    // sw: single MEM_write pulse
    start(6'd43, 6'd0, 1'b0, 1'b0); push(T_MADDR); push(T_SW); run();

    // branches
    start(6'd4, 6'd0, 1'b1, 1'b0); push(T_BR_T); run();
    start(6'd4, 6'd0, 1'b0, 1'b0); push(T_BR_N); run();
    start(6'd5, 6'd0, 1'b1, 1'b0); push(T_BR_N); run();
    start(6'd5, 6'd0, 1'b0, 1'b0); push(T_BR_T); run();

    // jump
    start(6'd2, 6'd0, 1'b0, 1'b0); push(T_J); run();

    // illegal opcode 63 and unsupported R-type funct
`ifdef OVERFLOW_EXC_EN
    start(6'd63, 6'd0, 1'b0, 1'b0); push(T_ILL); push(T_EXC); run();
    start(6'd0, 6'd0, 1'b0, 1'b0);  push(T_ILL); push(T_EXC); run();
`else
    start(6'd63, 6'd0, 1'b0, 1'b0); push(T_ILL); run();
    start(6'd0, 6'd0, 1'b0, 1'b0);  push(T_ILL); run();
`endif

    // reset asserted during DECODE aborts with no writeback
    start(6'd0, 6'd32, 1'b0, 1'b0);
    repeat (W + 2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    push(T_RST);
    reset = 1'b1;
    @(posedge clk); #1;

    // instruction after the abort runs normally
    start(6'd0, 6'd34, 1'b0, 1'b0); push(T_EXR_SUB); push(T_WBR); run();

    done = 1'b1;
  end

endmodule
